// File: rtl/gs_frame_receiver_if.sv
// Grayscale serial link bundle: SCLK/SIN/LAT from the driver side, decoded GS writes back.
// Optional GS_FRAME_RECEIVER_STATS_EN adds the word/error counters.
interface gs_frame_receiver_if #(
  parameter int unsigned SHIFT_WIDTH = 48,
  parameter int unsigned NB_WORDS    = 9
);
  localparam int unsigned ADDR_WIDTH = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

  logic                   sclk;
  logic                   sin;
  logic                   lat;
  logic                   gs_wr;
  logic [ADDR_WIDTH-1:0]  gs_wr_addr;
  logic [SHIFT_WIDTH-1:0] gs_wr_data;
  logic                   gs_commit;
  logic                   lat_err;
`ifdef GS_FRAME_RECEIVER_STATS_EN
  logic [15:0]            word_count;
  logic [7:0]             err_count;
`endif

  modport master (
`ifdef GS_FRAME_RECEIVER_STATS_EN
    input  word_count, err_count,
`endif
    output sclk, sin, lat,
    input  gs_wr, gs_wr_addr, gs_wr_data, gs_commit, lat_err
  );

  modport slave (
`ifdef GS_FRAME_RECEIVER_STATS_EN
    output word_count, err_count,
`endif
    input  sclk, sin, lat,
    output gs_wr, gs_wr_addr, gs_wr_data, gs_commit, lat_err
  );
endinterface

// File: rtl/gs_frame_receiver.sv
// LED-driver grayscale link receiver: oversamples SCLK/SIN/LAT, decodes LAT length into WRTGS/LATGS.
// Define GS_FRAME_RECEIVER_STATS_EN to add word_count/err_count outputs.
module gs_frame_receiver #(
  parameter int unsigned SHIFT_WIDTH     = 48,
  parameter int unsigned NB_WORDS        = 9,
  parameter int unsigned LAT_WRTGS_EDGES = 1,
  parameter int unsigned LAT_LATGS_EDGES = 3
) (
  input logic                clk,
  input logic                rst_n,
  gs_frame_receiver_if.slave link
);
  localparam int unsigned ADDR_WIDTH = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int unsigned CNT_WIDTH  = $clog2(SHIFT_WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LastSlot = ADDR_WIDTH'(NB_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0]  FullCnt  = CNT_WIDTH'(SHIFT_WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StLatch, StDecode} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sclk_sync_q, sin_sync_q, lat_sync_q;
  logic                   sclk_prev_q, lat_prev_q;
  logic [SHIFT_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]             lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic                   gs_wr_q, gs_wr_d;
  logic                   gs_commit_q, gs_commit_d;
  logic                   lat_err_q, lat_err_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SHIFT_WIDTH-1:0] data_q, data_d;

  logic sclk_rise, lat_rise, lat_fall, sin_s;
  logic is_wrtgs, is_latgs;

  // SIN shares SCLK's synchronizer depth so the sampled bit lines up with the detected edge.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign lat_rise  = lat_sync_q[1] & ~lat_prev_q;
  assign lat_fall  = ~lat_sync_q[1] & lat_prev_q;
  assign sin_s     = sin_sync_q[1];
  assign is_wrtgs  = (lat_cnt_q == 3'(LAT_WRTGS_EDGES));
  assign is_latgs  = (lat_cnt_q == 3'(LAT_LATGS_EDGES));

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    gs_wr_d     = 1'b0;
    gs_commit_d = 1'b0;
    lat_err_d   = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;

    if (sclk_rise) begin
      shreg_d = {shreg_q[SHIFT_WIDTH-2:0], sin_s};
      if (bit_cnt_q != FullCnt) bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      StIdle, StShift: begin
        if (lat_rise) begin
          state_d   = StLatch;
          lat_cnt_d = {2'b00, sclk_rise};
        end else if (sclk_rise) begin
          state_d = StShift;
        end
      end
      StLatch: begin
        if (sclk_rise && lat_cnt_q != 3'd7) lat_cnt_d = lat_cnt_q + 3'd1;
        if (lat_fall) state_d = StDecode;
      end
      StDecode: begin
        state_d   = StShift;
        bit_cnt_d = sclk_rise ? CNT_WIDTH'(1) : '0;
        if (is_wrtgs || is_latgs) begin
          gs_wr_d   = 1'b1;
          addr_d    = wr_ptr_q;
          data_d    = shreg_q;
          lat_err_d = (bit_cnt_q != FullCnt);
          if (is_latgs) begin
            gs_commit_d = 1'b1;
            wr_ptr_d    = LastSlot;
          end else begin
            wr_ptr_d = (wr_ptr_q == '0) ? LastSlot : wr_ptr_q - ADDR_WIDTH'(1);
          end
        end else begin
          lat_err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      sin_sync_q  <= '0;
      lat_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      lat_prev_q  <= 1'b0;
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      wr_ptr_q    <= LastSlot;
      gs_wr_q     <= 1'b0;
      gs_commit_q <= 1'b0;
      lat_err_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], link.sclk};
      sin_sync_q  <= {sin_sync_q[0], link.sin};
      lat_sync_q  <= {lat_sync_q[0], link.lat};
      sclk_prev_q <= sclk_sync_q[1];
      lat_prev_q  <= lat_sync_q[1];
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      gs_wr_q     <= gs_wr_d;
      gs_commit_q <= gs_commit_d;
      lat_err_q   <= lat_err_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign link.gs_wr      = gs_wr_q;
  assign link.gs_wr_addr = addr_q;
  assign link.gs_wr_data = data_q;
  assign link.gs_commit  = gs_commit_q;
  assign link.lat_err    = lat_err_q;

`ifdef GS_FRAME_RECEIVER_STATS_EN
  logic [15:0] word_count_q;
  logic [7:0]  err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      if (gs_wr_d) word_count_q <= word_count_q + 16'd1;
      if (lat_err_d && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign link.word_count = word_count_q;
  assign link.err_count  = err_count_q;
`endif
endmodule

// File: tb/tb_gs_frame_receiver.sv
// Directed bench for gs_frame_receiver: table of serial frames plus reset sequences.
module tb_gs_frame_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  gs_frame_receiver_if #(.SHIFT_WIDTH(48), .NB_WORDS(9)) link ();

  gs_frame_receiver #(
    .SHIFT_WIDTH    (48),
    .NB_WORDS       (9),
    .LAT_WRTGS_EDGES(1),
    .LAT_LATGS_EDGES(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .link (link)
  );

  typedef struct {
    int unsigned n_pre;
    int unsigned n_lat;
    logic [47:0] word;
    bit          coinc;
    bit          exp_wr;
    bit          exp_commit;
    bit          exp_err;
    logic [3:0]  exp_addr;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic        commit;
    logic        err;
    logic [3:0]  addr;
    logic [47:0] data;
  } ev_t;

  ev_t  ev_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wide_cnt = 0;
  logic prev_wr = 1'b0, prev_commit = 1'b0, prev_err = 1'b0;
  vec_t vecs[16];

  // Capture every output pulse and flag any that stays high for more than one clk.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((link.gs_wr && prev_wr) || (link.gs_commit && prev_commit) ||
          (link.lat_err && prev_err)) wide_cnt++;
      if (link.gs_wr || link.gs_commit || link.lat_err)
        ev_q.push_back('{link.gs_wr, link.gs_commit, link.lat_err, link.gs_wr_addr,
                         link.gs_wr_data});
    end
    prev_wr     = link.gs_wr;
    prev_commit = link.gs_commit;
    prev_err    = link.lat_err;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    link.sin  = b;
    link.sclk = 1'b0;
    wait_clk(5);
    link.sclk = 1'b1;
    wait_clk(5);
  endtask

  task automatic run_frame(input vec_t v);
    int unsigned n_tot;
    n_tot = v.n_pre + v.n_lat;
    for (int i = 0; i < int'(n_tot); i++) begin
      logic b;
      b = v.word[n_tot-1-i];
      if (i == int'(v.n_pre)) begin
        link.lat = 1'b1;
        wait_clk(6);
      end
      if (v.coinc && i == int'(n_tot) - 1) begin
        link.sin  = b;
        link.sclk = 1'b0;
        wait_clk(5);
        link.sclk = 1'b1;
        link.lat  = 1'b0;
        wait_clk(5);
      end else begin
        send_bit(b);
      end
    end
    if (v.n_lat == 0) begin
      link.lat = 1'b1;
      wait_clk(6);
    end
    if (!v.coinc) begin
      wait_clk(6);
      link.lat = 1'b0;
    end
    wait_clk(12);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    ev_t         e;
    logic [47:0] mask;
    int unsigned n_tot;
    n_tot = v.n_pre + v.n_lat;
    mask  = (n_tot >= 48) ? '1 : ((48'd1 << n_tot) - 48'd1);
    run_frame(v);
    check($sformatf("v%0d_events", idx), 64'(ev_q.size()), 64'd1);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      check($sformatf("v%0d_gs_wr", idx), 64'(e.wr), 64'(v.exp_wr));
      check($sformatf("v%0d_commit", idx), 64'(e.commit), 64'(v.exp_commit));
      check($sformatf("v%0d_lat_err", idx), 64'(e.err), 64'(v.exp_err));
      if (v.exp_wr) begin
        check($sformatf("v%0d_addr", idx), 64'(e.addr), 64'(v.exp_addr));
        check($sformatf("v%0d_data", idx), 64'(e.data & mask), 64'(v.word & mask));
      end
    end
    ev_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gs_wr"}, 64'(link.gs_wr), 64'd0);
    check({tag, "_commit"}, 64'(link.gs_commit), 64'd0);
    check({tag, "_lat_err"}, 64'(link.lat_err), 64'd0);
    check({tag, "_addr"}, 64'(link.gs_wr_addr), 64'd0);
    check({tag, "_data"}, 64'(link.gs_wr_data), 64'd0);
`ifdef GS_FRAME_RECEIVER_STATS_EN
    check({tag, "_word_count"}, 64'(link.word_count), 64'd0);
    check({tag, "_err_count"}, 64'(link.err_count), 64'd0);
`endif
  endtask

  initial begin
    // n_pre bits with LAT low, then n_lat bits with LAT high; word bits sent MSB first.
    vecs[0]  = '{47, 1, 48'hA5A5_0000_FFFF, 0, 1, 0, 0, 4'd8};
    vecs[1]  = '{47, 1, 48'h1111_2222_3333, 0, 1, 0, 0, 4'd7};
    vecs[2]  = '{47, 1, 48'h4444_5555_6666, 0, 1, 0, 0, 4'd6};
    vecs[3]  = '{47, 1, 48'h7777_8888_9999, 0, 1, 0, 0, 4'd5};
    vecs[4]  = '{47, 1, 48'hAAAA_BBBB_CCCC, 0, 1, 0, 0, 4'd4};
    vecs[5]  = '{47, 1, 48'hDDDD_EEEE_FFFF, 0, 1, 0, 0, 4'd3};
    vecs[6]  = '{47, 1, 48'h0123_0456_0789, 0, 1, 0, 0, 4'd2};
    vecs[7]  = '{47, 1, 48'hFEDC_BA98_7654, 0, 1, 0, 0, 4'd1};
    vecs[8]  = '{47, 1, 48'h8000_0000_0001, 0, 1, 0, 0, 4'd0};
    vecs[9]  = '{45, 3, 48'h0123_4567_89AB, 0, 1, 1, 0, 4'd8};
    vecs[10] = '{46, 2, 48'h5555_AAAA_5555, 0, 0, 0, 1, 4'd0};
    vecs[11] = '{48, 0, 48'h3C3C_3C3C_3C3C, 0, 0, 0, 1, 4'd0};
    vecs[12] = '{19, 1, 48'h0000_000A_BCDE, 0, 1, 0, 1, 4'd8};
    vecs[13] = '{45, 3, 48'hDEAD_BEEF_CAFE, 1, 1, 1, 0, 4'd7};
    vecs[14] = '{47, 1, 48'h0F0F_F0F0_1234, 0, 1, 0, 0, 4'd8};
    vecs[15] = '{47, 1, 48'hCAFE_F00D_BEEF, 0, 1, 0, 0, 4'd8};

    link.sclk = 1'b0;
    link.sin  = 1'b0;
    link.lat  = 1'b0;

    // Reset held while the link toggles.
    #3 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    link.sclk = 1'b0;
    wait_clk(2);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wait_clk(20);
    check("reset_no_pulse", 64'(ev_q.size()), 64'd0);
    ev_q.delete();

    for (int i = 0; i < 15; i++) apply_vec(i, vecs[i]);

`ifdef GS_FRAME_RECEIVER_STATS_EN
    check("stats_word_count", 64'(link.word_count), 64'd13);
    check("stats_err_count", 64'(link.err_count), 64'd3);
`endif

    // Reset mid-word: partial data discarded, pointer back to the last slot.
    for (int i = 0; i < 20; i++) send_bit(1'b1);
    link.sclk = 1'b0;
    wait_clk(3);
    rst_n = 1'b0;
    wait_clk(3);
    check_outputs_zero("midword_reset");
    rst_n = 1'b1;
    wait_clk(20);
    check("midword_no_pulse", 64'(ev_q.size()), 64'd0);
    ev_q.delete();
    apply_vec(15, vecs[15]);
`ifdef GS_FRAME_RECEIVER_STATS_EN
    check("stats_after_reset_words", 64'(link.word_count), 64'd1);
    check("stats_after_reset_errs", 64'(link.err_count), 64'd0);
`endif

    check("pulse_width", 64'(wide_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
